// File: rtl/line_buf_pkg.sv
// Shared defaults and sizing helpers for the line-shift buffer family.
package line_buf_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_IMG_HDISP = 640;
  localparam int unsigned DEF_TAP_NUM   = 2;

  // ceil(log2(v)), never less than 1 so a 1-entry range still gets a bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/line_buf_sdp_ram.sv
// Simple dual-port line RAM: synchronous write, registered read that holds when not enabled.
module line_buf_sdp_ram
  import line_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_IMG_HDISP,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  // Storage is deliberately not reset; stale contents are hidden by fill masking upstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_shift_ram_ntap.sv
// N-line shift buffer with column-aligned taps, fill tracking, overflow and vsync awareness.
// Define LINE_SHIFT_BORDER_REPLICATE_EN to replicate the nearest valid line into unfilled taps.
module line_shift_ram_ntap
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned IMG_HDISP = DEF_IMG_HDISP,
  parameter int unsigned TAP_NUM   = DEF_TAP_NUM,
  localparam int unsigned ADDR_W   = clog2(IMG_HDISP),
  localparam int unsigned CNT_W    = clog2(TAP_NUM + 1)
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      pre_frame_vsync,
  input  logic                      pre_frame_href,
  input  logic                      clken,
  input  logic [DATA_W-1:0]         shiftin,
  output logic [DATA_W-1:0]         shiftout,
  output logic [TAP_NUM*DATA_W-1:0] taps,
  output logic                      post_clken,
  output logic                      post_href,
  output logic [CNT_W-1:0]          lines_valid,
  output logic                      overflow
);

  localparam int unsigned COL_W = clog2(IMG_HDISP + 1);

  logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] shiftout_q, shiftout_d;
  logic [CNT_W-1:0]  lines_q, lines_d;
  logic              oor_q, oor_d;
  logic              overflow_q, overflow_d;
  logic              post_clken_q, post_href_q, vsync_q;

  logic              accept, in_range, vs_rise, line_end, rd_en, wr_en;
  logic [DATA_W-1:0] rd_data [TAP_NUM];
  logic [DATA_W-1:0] wr_data [TAP_NUM];
  logic [DATA_W-1:0] tap_sel;

  always_comb begin
    accept     = clken && pre_frame_href;
    in_range   = col_cnt_q < COL_W'(IMG_HDISP);
    vs_rise    = pre_frame_vsync && !vsync_q;
    line_end   = post_href_q && !pre_frame_href && (col_cnt_q != '0);
    rd_en      = accept && in_range;
    wr_en      = post_clken_q && !oor_q;
    col_cnt_d  = col_cnt_q;
    wr_addr_d  = wr_addr_q;
    shiftout_d = shiftout_q;
    oor_d      = oor_q;
    lines_d    = lines_q;
    overflow_d = overflow_q;

    if (!pre_frame_href)        col_cnt_d = '0;
    else if (accept && in_range) col_cnt_d = col_cnt_q + COL_W'(1);

    if (accept) begin
      shiftout_d = shiftin;
      oor_d      = !in_range;
      wr_addr_d  = ADDR_W'(col_cnt_q);
      if (!in_range) overflow_d = 1'b1;
    end

    // A new frame discards fill history even if a line ends in the same cycle.
    if (vs_rise) begin
      lines_d    = '0;
      overflow_d = 1'b0;
    end else if (line_end && (lines_q < CNT_W'(TAP_NUM))) begin
      lines_d = lines_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      wr_addr_q    <= '0;
      shiftout_q   <= '0;
      lines_q      <= '0;
      oor_q        <= 1'b0;
      overflow_q   <= 1'b0;
      post_clken_q <= 1'b0;
      post_href_q  <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      wr_addr_q    <= wr_addr_d;
      shiftout_q   <= shiftout_d;
      lines_q      <= lines_d;
      oor_q        <= oor_d;
      overflow_q   <= overflow_d;
      post_clken_q <= accept;
      post_href_q  <= pre_frame_href;
      vsync_q      <= pre_frame_vsync;
    end
  end

  // Each RAM takes the line the previous RAM just handed out, one cycle after the read.
  for (genvar k = 0; k < TAP_NUM; k++) begin : g_tap
    if (k == 0) begin : g_head
      assign wr_data[k] = shiftout_q;
    end else begin : g_chain
      assign wr_data[k] = rd_data[k-1];
    end

    line_buf_sdp_ram #(
      .DEPTH  (IMG_HDISP),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk     (clock),
      .rst_n   (rst_n),
      .rd_en   (rd_en),
      .rd_addr (ADDR_W'(col_cnt_q)),
      .rd_data (rd_data[k]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr_q),
      .wr_data (wr_data[k])
    );
  end

  always_comb begin
    taps    = '0;
    tap_sel = '0;
    for (int unsigned k = 0; k < TAP_NUM; k++) begin
`ifdef LINE_SHIFT_BORDER_REPLICATE_EN
      if (lines_q > CNT_W'(k))  tap_sel = rd_data[k];
      else if (lines_q == '0)   tap_sel = shiftout_q;
      else                      tap_sel = rd_data[lines_q - CNT_W'(1)];
`else
      tap_sel = (lines_q > CNT_W'(k)) ? rd_data[k] : '0;
`endif
      if (oor_q) tap_sel = '0;
      taps[tap_lsb(k, DATA_W) +: DATA_W] = tap_sel;
    end
  end

  assign shiftout    = shiftout_q;
  assign post_clken  = post_clken_q;
  assign post_href   = post_href_q;
  assign lines_valid = lines_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/line_shift_ram_ntap.md
Name: line_shift_ram_ntap

Overview:
- Parametrised successor of the two-line 8-bit line-shift buffer in the VIP matrix path.
- Stores TAP_NUM previous image lines of DATA_W-bit pixels and outputs the column-aligned pixel from each stored line alongside a delayed copy of the current pixel.
- Adds line-fill tracking, masking of unfilled taps, overflow detection and frame (vsync) awareness.
- Feeds 3x3/5x5/NxN window generators for filters (Sobel, median, Gaussian).

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_HDISP, 640, active pixels per line; sets RAM depth.
- TAP_NUM, 2, number of stored previous lines, 1..8.
- ADDR_W, derived as ceil(log2(IMG_HDISP)), column address width; not overridable.
- CNT_W, derived as ceil(log2(TAP_NUM+1)), width of lines_valid.

Ports:
- clock  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pre_frame_vsync  in  1  frame sync; a rising edge starts a new frame.
- pre_frame_href  in  1  line active.
- clken  in  1  pixel valid; ignored when href is low.
- shiftin  in  DATA_W  current-line pixel.
- shiftout  out  DATA_W  shiftin delayed 1 cycle, aligned to taps.
- taps  out  TAP_NUM*DATA_W  slice k holds the pixel from the line k+1 lines above; slice 0 = [DATA_W-1:0].
- post_clken  out  1  clken&&href delayed 1 cycle.
- post_href  out  1  href delayed 1 cycle.
- lines_valid  out  CNT_W  count of filled previous lines this frame, saturating at TAP_NUM.
- overflow  out  1  sticky flag: a line exceeded IMG_HDISP pixels.

Behaviour:
- Reset: all outputs, counters and pipeline registers go to 0. RAM contents are not cleared.
- Reset is asserted asynchronously and released synchronously to clock by the existing reset synchroniser.
- col_cnt:
  - Cleared while href is low.
  - Increments on each accepted pixel (clken && href) while col_cnt < IMG_HDISP.
  - At IMG_HDISP further pixels are not written, the taps for those pixels output 0, and overflow is set.
- Per accepted pixel at cycle t:
  - All TAP_NUM RAMs are read at col_cnt, with registered read data.
  - At t+1, RAM0 is written with shiftin delayed 1 cycle, and RAM k (k>=1) is written with the cycle-t read data of RAM k-1, all at the address delayed 1 cycle.
  - Read and write never target the same address in the same cycle.
- Latency: taps, shiftout and post_clken are valid exactly 1 cycle after clken is sampled. Gaps in clken stall the pipeline; outputs hold their values during gaps.
- Line counter:
  - Increments on the href falling edge when the ended line had at least 1 accepted pixel.
  - Saturates at TAP_NUM and drives lines_valid.
- Vsync rising edge: lines_valid and overflow are cleared the following cycle. If vsync and an href falling edge occur in the same cycle, vsync wins.
- Masking: taps slice k outputs 0 when lines_valid <= k.
- Reset mid-line: counters restart at 0. Stale RAM data stays hidden because lines_valid = 0.
- Short line (< IMG_HDISP pixels): only the written columns are updated; the remaining columns keep data from older lines.

Optional Feature:
- Macro: LINE_SHIFT_BORDER_REPLICATE_EN.
- Defined: unfilled taps replicate the nearest valid line instead of 0.
  - Slice k with k >= lines_valid outputs slice lines_valid-1.
  - If lines_valid = 0, slice k outputs shiftout.
- Undefined: unfilled taps output zero (zero-pad border).

Decomposition:
- Shared package line_buf_pkg holds:
  - the clog2 function,
  - the DATA_W/IMG_HDISP/TAP_NUM defaults,
  - a tap-index helper for slicing taps.
- Sub-module line_buf_sdp_ram: simple dual-port RAM (DEPTH, DATA_W) with a registered read and synchronous write, instantiated TAP_NUM times in a generate loop.

Test Plan:
- DATA_W=8, IMG_HDISP=8, TAP_NUM=2; 3 lines of continuous clken, pixel = line*16+col:
  - Line 2, col 3: shiftout=0x23, taps[0]=0x13, taps[1]=0x03.
  - lines_valid reads 0, then 1, then 2.
- clken toggling 1010 during line 1:
  - post_clken follows clken with exactly 1-cycle lag.
  - taps[0] steps through 0x00..0x07 with no skipped or duplicated column.
- Line of 10 pixels with IMG_HDISP=8:
  - overflow goes to 1 after pixel 8; taps read 0 for pixels 8 and 9.
  - Next vsync rising edge clears overflow to 0.
- Vsync after 3 lines, then 1 new line:
  - Without the macro: lines_valid=0 and taps=0 throughout.
  - With LINE_SHIFT_BORDER_REPLICATE_EN: both slices equal shiftout.
- rst_n pulsed low mid-line 2:
  - All outputs read 0 immediately (asynchronously).
  - After release, the first line restarts with lines_valid=0.
- TAP_NUM=4, 5 lines: on line 4, slice k equals pixel (3-k)*16+col for k=0..3.
